// File: rtl/btn_sw_conditioner.sv
// Button / switch input conditioner.
// Two-flop synchronizer and per-bit debounce for push-buttons and slide
// switches, registered press/release pulses for the buttons, and a
// wrap-around mode index stepped by button 0 and cleared by button 1.
// Optional build macro: BTN_AUTOREPEAT_EN adds auto-repeat press pulses
// on button 0 while it stays held.
module btn_sw_conditioner #(
    parameter int NB_BTN          = 4,
    parameter int NB_SW           = 4,
    parameter int NB_DEBOUNCE     = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int NB_MODE         = 2,
    parameter int N_MODES         = 3,
    parameter int REPEAT_CYCLES   = 50000
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [NB_BTN-1:0]  i_btn,
    input  logic [NB_SW-1:0]   i_sw,
    output logic [NB_BTN-1:0]  o_btn,
    output logic [NB_BTN-1:0]  o_btn_press,
    output logic [NB_BTN-1:0]  o_btn_release,
    output logic [NB_SW-1:0]   o_sw,
    output logic [NB_MODE-1:0] o_mode
);

    // Buttons occupy the low bits, switches the high bits of one vector.
    localparam int NB_IN = NB_BTN + NB_SW;
    localparam logic [NB_DEBOUNCE-1:0] DB_LAST   = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_DEBOUNCE-1:0] DB_ONE    = NB_DEBOUNCE'(1);
    localparam logic [NB_MODE-1:0]     MODE_LAST = NB_MODE'(N_MODES - 1);
    localparam logic [NB_MODE-1:0]     MODE_ONE  = NB_MODE'(1);

    // Elaboration-time parameter range checks.
    if (NB_BTN < 2) begin : g_bad_nb_btn
        $error("NB_BTN must be at least 2 (buttons 0 and 1 drive the mode)");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** NB_DEBOUNCE) - 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range for NB_DEBOUNCE");
    end
    if (N_MODES < 2 || N_MODES > (2 ** NB_MODE)) begin : g_bad_modes
        $error("N_MODES out of range for NB_MODE");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 1");
    end

    logic [NB_IN-1:0]       w_raw;
    logic [NB_IN-1:0]       r_sync1;
    logic [NB_IN-1:0]       r_sync2;
    logic [NB_IN-1:0]       r_stable;
    logic [NB_IN-1:0]       w_accept;
    logic [NB_IN-1:0]       w_stable_next;
    logic [NB_DEBOUNCE-1:0] r_cnt [NB_IN];
    logic [NB_BTN-1:0]      r_press;
    logic [NB_BTN-1:0]      r_release;
    logic [NB_BTN-1:0]      w_press_set;
    logic [NB_BTN-1:0]      w_release_set;
    logic                   w_rep_fire;
    logic [NB_MODE-1:0]     r_mode;

    assign w_raw = {i_sw, i_btn};

    // Two-flop synchronizer; the raw pins are used nowhere else.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A bit flips once its mismatch has been seen DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NB_IN; i++) begin
            w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == DB_LAST);
        end
        w_stable_next = r_stable ^ w_accept;
    end

    // Per-bit debounce counters and accepted levels; any match drops all credit.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_stable <= '0;
            for (int i = 0; i < NB_IN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable <= w_stable_next;
            for (int i = 0; i < NB_IN; i++) begin
                if ((r_sync2[i] == r_stable[i]) || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DB_ONE;
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int NB_REP = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [NB_REP-1:0] REP_LAST = NB_REP'(REPEAT_CYCLES - 1);
    localparam logic [NB_REP-1:0] REP_ONE  = NB_REP'(1);

    logic [NB_REP-1:0] r_rep_cnt;
    logic              w_held;

    // Button 0 counts as held only while it stays accepted across this edge.
    assign w_held     = r_stable[0] & w_stable_next[0];
    assign w_rep_fire = w_held && (r_rep_cnt == REP_LAST);

    // Repeat period counter, restarted from the initial press.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rep_cnt <= '0;
        end else if (!w_held || w_rep_fire) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + REP_ONE;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Edge detect on the accepted button levels, plus any repeat pulse on button 0.
    always_comb begin
        w_press_set    = w_stable_next[NB_BTN-1:0] & ~r_stable[NB_BTN-1:0];
        w_release_set  = ~w_stable_next[NB_BTN-1:0] & r_stable[NB_BTN-1:0];
        w_press_set[0] = w_press_set[0] | w_rep_fire;
    end

    // Pulses are flopped at the same edge the level changes, so they line up with o_btn.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_press   <= w_press_set;
            r_release <= w_release_set;
        end
    end

    // Mode index: button 1 clears (wins over button 0), button 0 steps with wrap.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_mode <= '0;
        end else if (r_press[1]) begin
            r_mode <= '0;
        end else if (r_press[0]) begin
            r_mode <= (r_mode == MODE_LAST) ? '0 : r_mode + MODE_ONE;
        end
    end

    assign o_btn         = r_stable[NB_BTN-1:0];
    assign o_sw          = r_stable[NB_IN-1:NB_BTN];
    assign o_btn_press   = r_press;
    assign o_btn_release = r_release;
    assign o_mode        = r_mode;

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Self-checking bench for btn_sw_conditioner with short debounce/repeat times.
// The reference model keeps a window of the last DC synchronized samples per bit
// and accepts a change when that whole window disagrees with the current level.
module tb_btn_sw_conditioner;

    localparam int DC  = 4;
    localparam int NM  = 3;
    localparam int REP = 20;

    logic       clock = 1'b0;
    logic       i_reset;
    logic [3:0] i_btn;
    logic [3:0] i_sw;
    logic [3:0] o_btn;
    logic [3:0] o_btn_press;
    logic [3:0] o_btn_release;
    logic [3:0] o_sw;
    logic [1:0] o_mode;

    int checks   = 0;
    int failures = 0;

    btn_sw_conditioner #(
        .NB_BTN(4), .NB_SW(4), .NB_DEBOUNCE(16), .DEBOUNCE_CYCLES(DC),
        .NB_MODE(2), .N_MODES(NM), .REPEAT_CYCLES(REP)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_btn(i_btn), .i_sw(i_sw),
        .o_btn(o_btn), .o_btn_press(o_btn_press), .o_btn_release(o_btn_release),
        .o_sw(o_sw), .o_mode(o_mode)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    bit [7:0] m_stable;
    bit [3:0] m_press;
    bit [3:0] m_release;
    int       m_mode;
    int       m_held;
    bit [7:0] m_raw_q[$];
    bit [7:0] m_obs_q[$];

    function automatic void model_reset();
        m_stable  = '0;
        m_press   = '0;
        m_release = '0;
        m_mode    = 0;
        m_held    = 0;
        m_raw_q   = {8'h00, 8'h00};
        m_obs_q   = {};
    endfunction

    function automatic void model_step(input bit [7:0] raw);
        bit [7:0] obs;
        bit [7:0] nxt;
        bit       all_diff;
        if (m_press[1])      m_mode = 0;
        else if (m_press[0]) m_mode = (m_mode + 1) % NM;
        m_raw_q.push_back(raw);
        obs = m_raw_q[m_raw_q.size() - 3];
        if (m_raw_q.size() > 3) void'(m_raw_q.pop_front());
        m_obs_q.push_back(obs);
        if (m_obs_q.size() > DC) void'(m_obs_q.pop_front());
        nxt = m_stable;
        for (int b = 0; b < 8; b++) begin
            all_diff = (m_obs_q.size() == DC);
            for (int k = 0; k < m_obs_q.size(); k++)
                if (m_obs_q[k][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nxt[b] = ~m_stable[b];
        end
        m_press   = nxt[3:0] & ~m_stable[3:0];
        m_release = ~nxt[3:0] & m_stable[3:0];
`ifdef BTN_AUTOREPEAT_EN
        if (nxt[0] && m_stable[0]) begin
            m_held++;
            if (m_held % REP == 0) m_press[0] = 1'b1;
        end else begin
            m_held = 0;
        end
`endif
        m_stable = nxt;
    endfunction

    function automatic logic [17:0] model_vec();
        return {m_stable[7:4], m_stable[3:0], m_press, m_release, 2'(m_mode)};
    endfunction

    // One clock: the model advances on the edge, outputs are observed on the negedge.
    task automatic cyc();
        @(posedge clock);
        if (!i_reset) model_reset();
        else model_step({i_sw, i_btn});
        @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_reset = 1'b0; i_btn = 4'hF; i_sw = 4'hF;
        model_reset();
        repeat (3) cyc();
        checks++;
        if ({o_btn, o_sw, o_btn_press, o_btn_release, o_mode} !== 18'd0) begin
            failures++;
            $display("FAIL reset_state got=%h want=0", {o_btn, o_sw, o_btn_press, o_btn_release, o_mode});
        end
        i_reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            checks++;
            if ({o_sw, o_btn, o_btn_press, o_btn_release, o_mode} !== model_vec()) begin
                failures++;
                $display("FAIL reset_release_model k=%0d got=%h want=%h", k,
                         {o_sw, o_btn, o_btn_press, o_btn_release, o_mode}, model_vec());
            end
            if (k == 5) begin
                checks++;
                if (o_btn !== 4'h0) begin
                    failures++; $display("FAIL reset_early_btn got=%h want=0", o_btn);
                end
            end
            if (k == 6) begin
                checks++;
                if ({o_btn, o_sw, o_btn_press} !== 12'hFFF) begin
                    failures++; $display("FAIL reset_accept got=%h want=fff", {o_btn, o_sw, o_btn_press});
                end
            end
            if (k == 7) begin
                checks++;
                if (o_btn_press !== 4'h0 || o_mode !== 2'd0) begin
                    failures++; $display("FAIL reset_pulse_width press=%h mode=%0d want 0/0", o_btn_press, o_mode);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int  np;
        int  rise;
        bit  seen_high;
        i_btn = 4'h0;
        repeat (12) begin
            cyc();
            checks++;
            if ({o_sw, o_btn, o_btn_press, o_btn_release, o_mode} !== model_vec()) begin
                failures++; $display("FAIL glitch_release_model got=%h want=%h",
                                     {o_sw, o_btn, o_btn_press, o_btn_release, o_mode}, model_vec());
            end
        end
        np = 0; seen_high = 1'b0;
        for (int k = 0; k < 13; k++) begin
            i_btn[0] = (k < 3);
            cyc();
            np += int'(o_btn_press[0]);
            if (o_btn[0]) seen_high = 1'b1;
            checks++;
            if ({o_sw, o_btn, o_btn_press, o_btn_release, o_mode} !== model_vec()) begin
                failures++; $display("FAIL glitch_model k=%0d got=%h want=%h", k,
                                     {o_sw, o_btn, o_btn_press, o_btn_release, o_mode}, model_vec());
            end
        end
        checks++;
        if (np != 0 || seen_high) begin
            failures++; $display("FAIL glitch_rejected pulses=%0d high=%0d want 0/0", np, seen_high);
        end
        np = 0; rise = -1;
        i_btn[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            np += int'(o_btn_press[0]);
            if (o_btn[0] && rise < 0) rise = k;
            checks++;
            if ({o_sw, o_btn, o_btn_press, o_btn_release, o_mode} !== model_vec()) begin
                failures++; $display("FAIL clean_press_model k=%0d got=%h want=%h", k,
                                     {o_sw, o_btn, o_btn_press, o_btn_release, o_mode}, model_vec());
            end
        end
        checks++;
        if (rise != 6 || np != 1) begin
            failures++; $display("FAIL clean_press_latency rise=%0d pulses=%0d want 6/1", rise, np);
        end
        i_btn = 4'h0;
        repeat (10) cyc();
    endtask

    task automatic test_mode_wrap();
        int exp_mode[4] = '{1, 2, 0, 1};
        int np;
        int nr;
        i_btn = 4'b0010;
        repeat (8) cyc();
        i_btn = 4'b0000;
        repeat (8) cyc();
        checks++;
        if (o_mode !== 2'd0) begin
            failures++; $display("FAIL mode_clear got=%0d want=0", o_mode);
        end
        for (int p = 0; p < 4; p++) begin
            i_btn[0] = 1'b1;
            for (int k = 0; k < 8; k++) begin
                cyc();
                checks++;
                if ({o_sw, o_btn, o_btn_press, o_btn_release, o_mode} !== model_vec()) begin
                    failures++; $display("FAIL mode_wrap_model p=%0d k=%0d got=%h want=%h", p, k,
                                         {o_sw, o_btn, o_btn_press, o_btn_release, o_mode}, model_vec());
                end
            end
            checks++;
            if (int'(o_mode) != exp_mode[p]) begin
                failures++; $display("FAIL mode_step p=%0d got=%0d want=%0d", p, o_mode, exp_mode[p]);
            end
            np = 0; nr = 0;
            i_btn[0] = 1'b0;
            repeat (8) begin
                cyc();
                np += int'(o_btn_press[0]);
                nr += int'(o_btn_release[0]);
            end
            checks++;
            if (np != 0 || nr != 1 || int'(o_mode) != exp_mode[p]) begin
                failures++; $display("FAIL mode_release p=%0d press=%0d rel=%0d mode=%0d want 0/1/%0d",
                                     p, np, nr, o_mode, exp_mode[p]);
            end
        end
    endtask

    task automatic test_priority();
        bit both;
        i_btn = 4'b0001;
        repeat (8) cyc();
        i_btn = 4'b0000;
        repeat (8) cyc();
        checks++;
        if (o_mode !== 2'd2) begin
            failures++; $display("FAIL priority_setup got=%0d want=2", o_mode);
        end
        both = 1'b0;
        i_btn = 4'b0011;
        repeat (9) begin
            cyc();
            if (o_btn_press[1:0] == 2'b11) both = 1'b1;
            checks++;
            if ({o_sw, o_btn, o_btn_press, o_btn_release, o_mode} !== model_vec()) begin
                failures++; $display("FAIL priority_model got=%h want=%h",
                                     {o_sw, o_btn, o_btn_press, o_btn_release, o_mode}, model_vec());
            end
        end
        checks++;
        if (!both || o_mode !== 2'd0) begin
            failures++; $display("FAIL priority both=%0d mode=%0d want 1/0", both, o_mode);
        end
        i_btn = 4'b0000;
        repeat (10) cyc();
    endtask

    task automatic test_switch();
        int  rise;
        bit  moved;
        i_sw = 4'h0;
        repeat (10) cyc();
        rise = -1;
        i_sw = 4'b1001;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (o_sw == 4'b1001 && rise < 0) rise = k;
            checks++;
            if ({o_sw, o_btn, o_btn_press, o_btn_release, o_mode} !== model_vec()) begin
                failures++; $display("FAIL switch_model k=%0d got=%h want=%h", k,
                                     {o_sw, o_btn, o_btn_press, o_btn_release, o_mode}, model_vec());
            end
        end
        checks++;
        if (rise != 6) begin
            failures++; $display("FAIL switch_latency got=%0d want=6", rise);
        end
        moved = 1'b0;
        for (int k = 0; k < 12; k++) begin
            i_sw = (k < 2) ? 4'b0001 : 4'b1001;
            cyc();
            if (o_sw !== 4'b1001) moved = 1'b1;
        end
        checks++;
        if (moved) begin
            failures++; $display("FAIL switch_glitch o_sw=%h moved=%0d want 9/0", o_sw, moved);
        end
    endtask

    task automatic test_autorepeat();
        int acc;
        int np;
        int want_np;
        int gap_bad;
        int last;
        acc = -1; np = 0; gap_bad = 0; last = -1;
        i_btn = 4'b0001;
        for (int k = 1; k <= 80; k++) begin
            cyc();
            if (o_btn[0] && acc < 0) acc = k;
            if (o_btn_press[0] && (acc < 0 || k <= acc + 70)) begin
                np++;
                if (last >= 0 && k - last != REP) gap_bad++;
                last = k;
            end
            checks++;
            if ({o_sw, o_btn, o_btn_press, o_btn_release, o_mode} !== model_vec()) begin
                failures++; $display("FAIL repeat_model k=%0d got=%h want=%h", k,
                                     {o_sw, o_btn, o_btn_press, o_btn_release, o_mode}, model_vec());
            end
            if (acc < 0 && k > 20) break;
        end
`ifdef BTN_AUTOREPEAT_EN
        want_np = 4;
`else
        want_np = 1;
`endif
        checks++;
        if (acc < 0 || np != want_np || gap_bad != 0 || o_mode !== 2'd1) begin
            failures++; $display("FAIL repeat acc=%0d pulses=%0d badgap=%0d mode=%0d want pulses=%0d mode=1",
                                 acc, np, gap_bad, o_mode, want_np);
        end
        i_btn = 4'b0000;
        repeat (10) cyc();
    endtask

    task automatic test_reset_mid();
        int rise;
        int np;
        i_btn = 4'b0100;
        repeat (4) cyc();
        i_reset = 1'b0;
        model_reset();
        repeat (2) cyc();
        i_reset = 1'b1;
        rise = -1; np = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (o_btn[2] && rise < 0) rise = k;
            np += int'(o_btn_press[2]);
            checks++;
            if ({o_sw, o_btn, o_btn_press, o_btn_release, o_mode} !== model_vec()) begin
                failures++; $display("FAIL reset_mid_model k=%0d got=%h want=%h", k,
                                     {o_sw, o_btn, o_btn_press, o_btn_release, o_mode}, model_vec());
            end
        end
        checks++;
        if (rise != 6 || np != 1) begin
            failures++; $display("FAIL reset_mid rise=%0d pulses=%0d want 6/1", rise, np);
        end
        i_btn = 4'b0000;
        repeat (10) cyc();
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) i_btn = i_btn ^ 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) i_sw  = i_sw  ^ 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                i_reset = 1'b0;
                model_reset();
            end else begin
                i_reset = 1'b1;
            end
            cyc();
            checks++;
            if ({o_sw, o_btn, o_btn_press, o_btn_release, o_mode} !== model_vec()) begin
                failures++; $display("FAIL random_model k=%0d got=%h want=%h", k,
                                     {o_sw, o_btn, o_btn_press, o_btn_release, o_mode}, model_vec());
            end
        end
        i_reset = 1'b1;
    endtask

    initial begin
        i_reset = 1'b0; i_btn = '0; i_sw = '0;
        @(negedge clock);
        test_reset();
        test_glitch();
        test_mode_wrap();
        test_priority();
        test_switch();
        test_autorepeat();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
